// File: rtl/ddr_burst_writer_if.sv
// Bus bundle between ddr_burst_writer, its source FIFO and the MIG app/wdf port.
// master: FIFO read side + app/wdf command and data outputs; slave: the other end.
interface ddr_burst_writer_if #(
    parameter int pADDR_WIDTH = 30
);
    logic                   fifo_rd;
    logic [63:0]            fifo_dout;
    logic                   fifo_empty;
    logic                   app_en;
    logic [2:0]             app_cmd;
    logic [pADDR_WIDTH-1:0] app_addr;
    logic                   app_rdy;
    logic                   app_wdf_wren;
    logic [63:0]            app_wdf_data;
    logic                   app_wdf_end;
    logic                   app_wdf_rdy;

    modport master (
        output fifo_rd,
        input  fifo_dout,
        input  fifo_empty,
        output app_en,
        output app_cmd,
        output app_addr,
        input  app_rdy,
        output app_wdf_wren,
        output app_wdf_data,
        output app_wdf_end,
        input  app_wdf_rdy
    );

    modport slave (
        input  fifo_rd,
        output fifo_dout,
        output fifo_empty,
        input  app_en,
        input  app_cmd,
        input  app_addr,
        output app_rdy,
        input  app_wdf_wren,
        input  app_wdf_data,
        input  app_wdf_end,
        output app_wdf_rdy
    );
endinterface

// File: rtl/ddr_burst_writer.sv
// Drains the 64-bit pre-DDR FIFO into pBURST_LEN-beat MIG write bursts.
// Ports: clk, reset, enabled, capture_start, capture_done_in, io (bus),
// write_done, ddr_full, words_written.
module ddr_burst_writer #(
    parameter int     pADDR_WIDTH = 30,
    parameter int     pBURST_LEN  = 8,
    parameter longint pMAX_ADDR   = 64'd1073741823
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enabled,
    input  logic                capture_start,
    input  logic                capture_done_in,
    ddr_burst_writer_if.master  io,
    output logic                write_done,
    output logic                ddr_full,
    output logic [31:0]         words_written
);
    localparam int BW = $clog2(pBURST_LEN);
    localparam int CW = BW + 1;
    localparam int BURST_BYTES = pBURST_LEN * 8;
    localparam logic [BW-1:0] LAST = BW'(pBURST_LEN - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(pBURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_CMD, S_DATA, S_FULL, S_DONE
    } state_t;

    state_t                 state;
    logic [pADDR_WIDTH-1:0] addr;
    logic [CW-1:0]          fill_cnt;
    logic [BW-1:0]          beat;
    logic                   rd_inflight;
    logic                   done_pending;
    logic                   restart_pending;
    logic [63:0]            bq [pBURST_LEN];
    logic                   last_acc;
    logic                   restart_now;
    logic                   no_room;

    assign io.app_cmd = 3'b000;

    // Slots past fill_cnt belong to a padded final burst.
    function automatic logic [63:0] beat_word(input logic [CW-1:0] idx);
        return (idx < fill_cnt) ? bq[idx[BW-1:0]] : 64'h0;
    endfunction

    always_comb begin
        io.fifo_rd = 1'b0;
        if (enabled && !io.fifo_empty) begin
            if (state == S_FILL)
                io.fifo_rd = (fill_cnt + CW'(rd_inflight)) < FULL_CNT;
            else if (state == S_FULL)
                io.fifo_rd = 1'b1;
        end
    end

    assign last_acc = (state == S_DATA) && io.app_wdf_wren &&
                      io.app_wdf_rdy && (beat == LAST);

    // Would the burst after the one just finishing overrun the space?
    assign no_room = (64'(addr) + 64'(2 * BURST_BYTES) - 64'd1) >
                     64'(pMAX_ADDR);

    always_comb begin
        restart_now = 1'b0;
        unique case (state)
            S_IDLE:                 restart_now = enabled && capture_start;
            S_FILL, S_FULL, S_DONE: restart_now = capture_start;
            S_DATA:                 restart_now = last_acc &&
                                        (restart_pending || capture_start);
            default:                restart_now = 1'b0;
        endcase
    end

    // Data buffer needs no reset; fill_cnt qualifies every slot.
    always_ff @(posedge clk) begin
        if (state == S_FILL && rd_inflight)
            bq[fill_cnt[BW-1:0]] <= io.fifo_dout;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            addr            <= '0;
            fill_cnt        <= '0;
            beat            <= '0;
            rd_inflight     <= 1'b0;
            done_pending    <= 1'b0;
            restart_pending <= 1'b0;
            write_done      <= 1'b0;
            ddr_full        <= 1'b0;
            words_written   <= '0;
            io.app_en       <= 1'b0;
            io.app_addr     <= '0;
            io.app_wdf_wren <= 1'b0;
            io.app_wdf_data <= '0;
            io.app_wdf_end  <= 1'b0;
        end else begin
            if (state != S_IDLE && capture_done_in)
                done_pending <= 1'b1;
            if (capture_start && (state == S_CMD || state == S_DATA))
                restart_pending <= 1'b1;
            rd_inflight <= io.fifo_rd && (state == S_FILL);
            write_done  <= 1'b0;

            unique case (state)
                S_IDLE: begin
                end
                S_FILL: begin
                    if (rd_inflight) begin
                        fill_cnt <= fill_cnt + CW'(1);
                        if (words_written != 32'hFFFF_FFFF)
                            words_written <= words_written + 32'd1;
                    end
                    if (fill_cnt == FULL_CNT) begin
                        state       <= S_CMD;
                        io.app_en   <= 1'b1;
                        io.app_addr <= addr;
                    end else if (done_pending && io.fifo_empty &&
                                 !rd_inflight) begin
                        if (fill_cnt != '0) begin
                            state       <= S_CMD;
                            io.app_en   <= 1'b1;
                            io.app_addr <= addr;
                        end else begin
                            state        <= S_DONE;
                            write_done   <= 1'b1;
                            done_pending <= 1'b0;
                        end
                    end
                end
                S_CMD: begin
                    if (io.app_rdy) begin
                        io.app_en       <= 1'b0;
                        state           <= S_DATA;
                        beat            <= '0;
                        io.app_wdf_wren <= 1'b1;
                        io.app_wdf_data <= beat_word('0);
                        io.app_wdf_end  <= 1'b0;
                    end
                end
                S_DATA: begin
                    if (io.app_wdf_rdy) begin
                        if (beat == LAST) begin
                            io.app_wdf_wren <= 1'b0;
                            io.app_wdf_end  <= 1'b0;
                            addr     <= addr + pADDR_WIDTH'(BURST_BYTES);
                            fill_cnt <= '0;
                            if (no_room) begin
                                state    <= S_FULL;
                                ddr_full <= 1'b1;
                            end else begin
                                state <= S_FILL;
                            end
                        end else begin
                            beat            <= beat + BW'(1);
                            io.app_wdf_data <= beat_word(CW'(beat) + CW'(1));
                            io.app_wdf_end  <= (beat + BW'(1)) == LAST;
                        end
                    end
                end
                S_FULL: begin
                    if (done_pending) begin
                        state        <= S_DONE;
                        write_done   <= 1'b1;
                        done_pending <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Restart wins over the normal transition; a word still
            // returning from the FIFO is dropped with rd_inflight.
            if (restart_now) begin
                state           <= S_FILL;
                addr            <= '0;
                fill_cnt        <= '0;
                rd_inflight     <= 1'b0;
                words_written   <= '0;
                ddr_full        <= 1'b0;
                done_pending    <= 1'b0;
                restart_pending <= 1'b0;
                write_done      <= 1'b0;
                io.app_en       <= 1'b0;
                io.app_wdf_wren <= 1'b0;
                io.app_wdf_end  <= 1'b0;
            end

            if (!enabled) begin
                state           <= S_IDLE;
                rd_inflight     <= 1'b0;
                done_pending    <= 1'b0;
                restart_pending <= 1'b0;
                write_done      <= 1'b0;
                io.app_en       <= 1'b0;
                io.app_wdf_wren <= 1'b0;
                io.app_wdf_end  <= 1'b0;
            end
        end
    end
endmodule
